ls191_counter_sequencer: RTL and testbench
==========================================

Name: ls191_counter_sequencer

Overview:
- Sequences and shares one cascaded LS191-style up/down counter chain (W bits) among NREQ requesters, e.g. CPU position writes and the motion-object engine.
- Each request is either a parallel LOAD of a value, or a RUN of N count steps up or down.
- Round-robin arbitration between requesters.
- Drives the chain's active-low load, active-low count enable, direction and data pins, and monitors its MaxMin output to stop at the count limit.

Parameters:
- W, 8, counter chain width and width of each request data field.
- NREQ, 2, number of requesters.
- STOP_AT_LIMIT, 1, when 1 a RUN terminates early with error instead of wrapping past 0/max.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_load  input  NREQ  per requester: 1 = LOAD, 0 = RUN.
- req_dir  input  NREQ  per requester: 1 = count down, 0 = count up (RUN only).
- req_data  input  NREQ*W  per requester: load value (LOAD) or step count (RUN); requester i uses bits [i*W +: W].
- ack  output  NREQ  one-cycle done pulse to the granted requester.
- err  output  1  valid with ack: RUN stopped at limit before all steps completed.
- busy  output  1  high whenever state is not IDLE.
- ctr_load_n  output  1  active-low parallel load to the counter chain.
- ctr_cten_n  output  1  active-low count enable to the counter chain.
- ctr_du  output  1  direction to the counter chain (1 = down).
- ctr_d  output  W  parallel load data to the counter chain.
- ctr_maxmin  input  1  MaxMin from the counter chain: max when counting up, 0 when counting down.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - Outputs: ack=0, err=0, busy=0, ctr_load_n=1, ctr_cten_n=1, ctr_du=0, ctr_d=0.
  - Internal: state=IDLE, round-robin pointer=0 (requester 0 has top priority), remaining-step counter=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - Latch the granted requester's index, load flag, dir and data.
  - Pointer becomes grant+1 mod NREQ.
  - Next state is LOAD if load flag=1; else RUN if data!=0; else DONE.
  - A RUN with data=0 completes with no count pulses and err=0.
- LOAD:
  - Exactly one cycle with ctr_load_n=0 and ctr_d=latched data.
  - ctr_load_n and ctr_d are registered outputs.
  - Next state is DONE.
- RUN:
  - ctr_du = latched dir (registered, set on entry).
  - ctr_cten_n = 0 combinationally while state==RUN, unless STOP_AT_LIMIT=1 and ctr_maxmin=1.
  - Each RUN cycle with ctr_cten_n=0 is one counted step; remaining is decremented.
  - When remaining==1 during a counted step, next state is DONE with err=0.
  - If STOP_AT_LIMIT=1 and ctr_maxmin=1: no step is taken that cycle, next state is DONE with err=1.
  - If STOP_AT_LIMIT=0, the counter wraps freely and err stays 0.
- DONE:
  - ack[granted]=1 and err are registered and valid for exactly this one cycle.
  - Next state is IDLE.
- Handshake:
  - req_valid and the requester's fields must be held stable until its ack.
  - req_valid must be low in the cycle after ack, or the request is treated as new.
  - Requests arriving while busy=1 wait; they are never lost or reordered against the pointer.
- Latency:
  - LOAD: grant edge to ack = 2 cycles.
  - RUN of N steps: ack N+1 cycles after grant.
- At most one counter operation is in flight. ctr_load_n and ctr_cten_n are never low simultaneously.
- Reset mid-operation:
  - Abort to IDLE with no ack.
  - ctr_load_n and ctr_cten_n return high on the reset edge.
  - Counter chain contents are left untouched.

Test Plan:
- Reset, then req_valid=01, req_load=1, data0=0x5A -> ctr_load_n low for exactly 1 cycle with ctr_d=0x5A; ack=01 on the 2nd cycle after grant; err=0; busy high for 2 cycles.
- Counter at 0x10, requester 1 RUN up with data=3 -> ctr_cten_n low for 3 cycles, ctr_du=0, counter reaches 0x13, ack=10, err=0.
- Counter at 0x02, RUN down with data=5, STOP_AT_LIMIT=1 -> 2 counted steps, ctr_maxmin=1 at 0x00, ack with err=1, counter holds 0x00; repeat with STOP_AT_LIMIT=0 -> counter reaches 0xFD, err=0.
- Both requesters hold valid continuously, each issuing LOAD -> grants alternate 0,1,0,1 with back-to-back acks; no requester is granted twice in a row.
- RUN with data=0 -> no ctr_cten_n pulse; ack one cycle after grant.
- Assert reset during RUN step 2 of 6 -> no ack, ctr_cten_n=1 and busy=0 after the reset edge, pointer=0; next request is serviced normally.

Source files
------------

// File: rtl/ls191_counter_sequencer.sv
// Arbitrates NREQ requesters onto one shared LS191-style up/down counter chain.
// Each grant either parallel-loads the chain or runs it N steps, stopping at MaxMin if enabled.
module ls191_counter_sequencer #(
  parameter int W             = 8,
  parameter int NREQ          = 2,
  parameter int STOP_AT_LIMIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_load,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic              ctr_load_n,
  output logic              ctr_cten_n,
  output logic              ctr_du,
  output logic [W-1:0]      ctr_d,
  input  logic              ctr_maxmin
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gnt_q;
  logic [W-1:0]    rem_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;
  logic            load_n_q;
  logic            du_q;
  logic [W-1:0]    d_q;

  logic [NREQ-1:0] rot_d;
  logic            found_d;
  logic [PW-1:0]   gnt_d;
  logic [PW-1:0]   ptr_nx_d;
  logic            sel_load_d;
  logic            sel_dir_d;
  logic [W-1:0]    sel_data_d;
  logic            limit_d;
  logic            step_d;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'((v >= NREQ) ? v - NREQ : v);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Rotate so bit 0 is the pointer's requester; the lowest set bit wins.
  always_comb begin
    rot_d   = NREQ'({req_valid, req_valid} >> ptr_q);
    found_d = 1'b0;
    gnt_d   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_d[k]) begin
        found_d = 1'b1;
        gnt_d   = wrap(int'(ptr_q) + k);
      end
    end
    ptr_nx_d = wrap(int'(gnt_d) + 1);
  end

  assign sel_load_d = req_load[gnt_d];
  assign sel_dir_d  = req_dir[gnt_d];
  assign sel_data_d = req_data[gnt_d*W +: W];

  assign limit_d = (STOP_AT_LIMIT != 0) && ctr_maxmin;
  assign step_d  = (state_q == RUN) && !limit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rem_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      load_n_q <= 1'b1;
      du_q     <= 1'b0;
      d_q      <= '0;
    end else begin
      ack_q    <= '0;
      err_q    <= 1'b0;
      load_n_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_nx_d;
            rem_q <= sel_data_d;
            if (sel_load_d) begin
              state_q  <= LOAD;
              load_n_q <= 1'b0;
              d_q      <= sel_data_d;
            end else if (sel_data_d != '0) begin
              state_q <= RUN;
              du_q    <= sel_dir_d;
            end else begin
              state_q <= DONE;
              ack_q   <= onehot(gnt_d);
            end
          end
        end
        LOAD: begin
          state_q <= DONE;
          ack_q   <= onehot(gnt_q);
        end
        RUN: begin
          // At the limit the chain is held (cten high) and the run ends with an error.
          if (limit_d) begin
            state_q <= DONE;
            ack_q   <= onehot(gnt_q);
            err_q   <= 1'b1;
          end else begin
            rem_q <= rem_q - W'(1);
            if (rem_q == W'(1)) begin
              state_q <= DONE;
              ack_q   <= onehot(gnt_q);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign ctr_load_n = load_n_q;
  assign ctr_cten_n = !step_d;
  assign ctr_du     = du_q;
  assign ctr_d      = d_q;

endmodule

// File: tb/tb_ls191_counter_sequencer.sv
// Scoreboard bench: two sequencers (stop-at-limit and wrapping) each driving a modelled LS191 chain.
module tb_ls191_counter_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] rv   [2];
  logic [1:0] rl   [2];
  logic [1:0] rdir [2];
  logic [15:0] rd  [2];
  logic [7:0] cnt  [2];

  wire  [1:0] ak [2];
  wire  [7:0] cd [2];
  wire  [1:0] er, bs, ldn, ctn, du, mm;

  ls191_counter_sequencer #(.W(8), .NREQ(2), .STOP_AT_LIMIT(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_load(rl[0]), .req_dir(rdir[0]),
    .req_data(rd[0]), .ack(ak[0]), .err(er[0]), .busy(bs[0]), .ctr_load_n(ldn[0]),
    .ctr_cten_n(ctn[0]), .ctr_du(du[0]), .ctr_d(cd[0]), .ctr_maxmin(mm[0]));

  ls191_counter_sequencer #(.W(8), .NREQ(2), .STOP_AT_LIMIT(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_load(rl[1]), .req_dir(rdir[1]),
    .req_data(rd[1]), .ack(ak[1]), .err(er[1]), .busy(bs[1]), .ctr_load_n(ldn[1]),
    .ctr_cten_n(ctn[1]), .ctr_du(du[1]), .ctr_d(cd[1]), .ctr_maxmin(mm[1]));

  // Behavioural LS191 chain: unaffected by the sequencer reset.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ldn[u] === 1'b0) cnt[u] <= cd[u];
      else if (ctn[u] === 1'b0) cnt[u] <= du[u] ? cnt[u] - 8'd1 : cnt[u] + 8'd1;
    end
  end
  assign mm[0] = du[0] ? (cnt[0] == 8'h00) : (cnt[0] == 8'hFF);
  assign mm[1] = du[1] ? (cnt[1] == 8'h00) : (cnt[1] == 8'hFF);

  typedef struct {
    int         unit;
    logic [1:0] ack;
    logic       err;
    logic [7:0] cnt;
    int         steps;
    int         loads;
    int         busyc;
    logic       dir;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vec = 0;
  int   mis = 0;

  int         acc_steps [2];
  int         acc_loads [2];
  int         acc_busy  [2];
  logic [7:0] acc_d     [2];
  logic       acc_du    [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: accumulate per-operation activity, compare against the scoreboard on each ack.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset === 1'b1) begin
        acc_steps[u] = 0; acc_loads[u] = 0; acc_busy[u] = 0;
      end else begin
        if (ldn[u] === 1'b0 && ctn[u] === 1'b0)
          chk($sformatf("u%0d_load_cten_overlap", u), 1, 0);
        if (ldn[u] === 1'b0) begin acc_loads[u]++; acc_d[u] = cd[u]; end
        if (ctn[u] === 1'b0) begin acc_steps[u]++; acc_du[u] = du[u]; end
        if (bs[u] === 1'b1) acc_busy[u]++;
        if (ak[u] !== 2'b00) begin
          if (sb.size() == 0 || sb[0].unit != u) begin
            chk($sformatf("u%0d_unexpected_ack", u), 32'(ak[u]), 0);
          end else begin
            mon_e = sb.pop_front();
            chk($sformatf("u%0d_ack", u),   32'(ak[u]), 32'(mon_e.ack));
            chk($sformatf("u%0d_err", u),   32'(er[u]), 32'(mon_e.err));
            chk($sformatf("u%0d_cnt", u),   32'(cnt[u]), 32'(mon_e.cnt));
            chk($sformatf("u%0d_steps", u), acc_steps[u], mon_e.steps);
            chk($sformatf("u%0d_loads", u), acc_loads[u], mon_e.loads);
            chk($sformatf("u%0d_busy_cycles", u), acc_busy[u], mon_e.busyc);
            if (mon_e.loads > 0) chk($sformatf("u%0d_ctr_d", u), 32'(acc_d[u]), 32'(mon_e.d));
            if (mon_e.steps > 0) chk($sformatf("u%0d_ctr_du", u), 32'(acc_du[u]), 32'(mon_e.dir));
          end
          acc_steps[u] = 0; acc_loads[u] = 0; acc_busy[u] = 0;
        end
      end
    end
  end

  task automatic push(input int u, input int i, input bit ld, input bit dir, input logic [7:0] data,
                      input logic [7:0] xcnt, input bit xerr, input int xsteps, input int xbusy);
    exp_t e;
    e.unit = u; e.ack = 2'b01 << i; e.err = xerr; e.cnt = xcnt;
    e.steps = xsteps; e.loads = ld ? 1 : 0; e.busyc = xbusy; e.dir = dir; e.d = data;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int u, input int i);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (ak[u][i] === 1'b1) return;
    end
    chk($sformatf("u%0d_req%0d_ack_timeout", u, i), 0, 1);
  endtask

  task automatic drive(input int u, input int i, input bit ld, input bit dir, input logic [7:0] data);
    rl[u][i] = ld; rdir[u][i] = dir; rd[u][i*8 +: 8] = data; rv[u][i] = 1'b1;
  endtask

  task automatic do_load(input int u, input int i, input logic [7:0] data);
    push(u, i, 1'b1, 1'b0, data, data, 1'b0, 0, 2);
    drive(u, i, 1'b1, 1'b0, data);
    wait_ack(u, i);
    rv[u][i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_run(input int u, input int i, input bit dir, input logic [7:0] n,
                        input logic [7:0] xcnt, input bit xerr, input int xsteps, input int xbusy);
    push(u, i, 1'b0, dir, n, xcnt, xerr, xsteps, xbusy);
    drive(u, i, 1'b0, dir, n);
    wait_ack(u, i);
    rv[u][i] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      rv[u] = '0; rl[u] = '0; rdir[u] = '0; rd[u] = '0; cnt[u] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_ack", u),    32'(ak[u]), 0);
      chk($sformatf("u%0d_rst_err", u),    32'(er[u]), 0);
      chk($sformatf("u%0d_rst_busy", u),   32'(bs[u]), 0);
      chk($sformatf("u%0d_rst_load_n", u), 32'(ldn[u]), 1);
      chk($sformatf("u%0d_rst_cten_n", u), 32'(ctn[u]), 1);
      chk($sformatf("u%0d_rst_du", u),     32'(du[u]), 0);
      chk($sformatf("u%0d_rst_ctr_d", u),  32'(cd[u]), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // LOAD 0x5A from requester 0.
    do_load(0, 0, 8'h5A);
    // Counter to 0x10, then requester 1 RUN up 3 -> 0x13.
    do_load(0, 1, 8'h10);
    do_run(0, 1, 1'b0, 8'd3, 8'h13, 1'b0, 3, 4);
    // Counter to 0x02, RUN down 5 stops at 0x00 after 2 steps with err.
    do_load(0, 0, 8'h02);
    do_run(0, 0, 1'b1, 8'd5, 8'h00, 1'b1, 2, 4);
    // RUN of zero steps: immediate ack, no count pulse.
    do_run(0, 1, 1'b0, 8'd0, 8'h00, 1'b0, 0, 1);
    // Up-count limit: 0xFE, RUN up 3 -> one step to 0xFF then stop with err.
    do_load(0, 0, 8'hFE);
    do_run(0, 1, 1'b0, 8'd3, 8'hFF, 1'b1, 1, 3);

    // Both requesters hold LOAD requests: grants alternate 0,1,0,1.
    push(0, 0, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 0, 2);
    push(0, 1, 1'b1, 1'b0, 8'h22, 8'h22, 1'b0, 0, 2);
    push(0, 0, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 0, 2);
    push(0, 1, 1'b1, 1'b0, 8'h22, 8'h22, 1'b0, 0, 2);
    drive(0, 0, 1'b1, 1'b0, 8'h11);
    drive(0, 1, 1'b1, 1'b0, 8'h22);
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(posedge clk); #1;
      if (ak[0] !== 2'b00) n++;
    end
    if (n < 4) chk("alternate_ack_timeout", n, 4);
    rv[0] = 2'b00;
    @(posedge clk); #1;

    // Reset during step 2 of a 6-step RUN from 0x22.
    drive(0, 0, 1'b0, 1'b0, 8'd6);
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(posedge clk); #1;
      if (ctn[0] === 1'b0) n++;
    end
    if (n < 2) chk("run_start_timeout", n, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rv[0] = 2'b00;
    chk("abort_cten_n", 32'(ctn[0]), 1);
    chk("abort_load_n", 32'(ldn[0]), 1);
    chk("abort_busy",   32'(bs[0]), 0);
    chk("abort_ack",    32'(ak[0]), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_counter_kept", 32'(cnt[0]), 32'h24);

    // Pointer back at 0: with both pending, requester 0 goes first.
    push(0, 0, 1'b1, 1'b0, 8'h33, 8'h33, 1'b0, 0, 2);
    push(0, 1, 1'b1, 1'b0, 8'h44, 8'h44, 1'b0, 0, 2);
    drive(0, 0, 1'b1, 1'b0, 8'h33);
    drive(0, 1, 1'b1, 1'b0, 8'h44);
    wait_ack(0, 0);
    rv[0][0] = 1'b0;
    wait_ack(0, 1);
    rv[0][1] = 1'b0;
    @(posedge clk); #1;

    // Wrapping variant: 0x02 down 5 -> 0xFD, all steps, no err.
    do_load(1, 0, 8'h02);
    do_run(1, 0, 1'b1, 8'd5, 8'hFD, 1'b0, 5, 6);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
